// File: rtl/control_unit.sv
// Phase-2 datapath sequencer: fetch (T0-T2), decode of ir[31:27], execute T3-T7.
// MEM_WAIT sets how many cycles each RAM read holds Read/MDR_enable (1..7).
module control_unit #(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con_ff,
  output logic        PC_out,
  output logic        ZLow_out,
  output logic        ZHigh_out,
  output logic        HI_out,
  output logic        LO_out,
  output logic        C_out,
  output logic        In_port_out,
  output logic        MDR_out,
  output logic        BA_out,
  output logic        PC_enable,
  output logic        IncPC,
  output logic        MAR_enable,
  output logic        MDR_enable,
  output logic        IR_enable,
  output logic        Y_enable,
  output logic        Z_enable,
  output logic        HI_enable,
  output logic        LO_enable,
  output logic        Read,
  output logic        RAM_write_enable,
  output logic        out_port_enable,
  output logic        con_in,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        R_in,
  output logic        R_out,
  output logic [4:0]  opcode,
  output logic        run,
  output logic        illegal_op,
  output logic [3:0]  step
);

  typedef enum logic [3:0] {
    T0 = 4'd0, T1 = 4'd1, T2 = 4'd2, T3 = 4'd3, T4 = 4'd4, T5 = 4'd5, T6 = 4'd6, T7 = 4'd7,
    HALT = 4'hD, FAULT = 4'hE, RESET = 4'hF
  } state_t;

  typedef enum logic [3:0] {
    C_LD, C_LDI, C_ST, C_RRR, C_IMM, C_MULDIV, C_NEGNOT, C_BR,
    C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT, C_BAD
  } cls_t;

  localparam logic [2:0] WAIT_LOAD = 3'(MEM_WAIT - 1);

  state_t     state;
  cls_t       cls;
  logic [2:0] wait_cnt;
  logic [4:0] op;
  logic       unused_ir_bits;

  assign op             = ir[31:27];
  assign unused_ir_bits = ^ir[26:0];

  always_comb begin
    cls = C_BAD;
    case (op)
      5'd0:            cls = C_LD;
      5'd1:            cls = C_LDI;
      5'd2:            cls = C_ST;
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11:
                       cls = C_RRR;
      5'd12, 5'd13, 5'd14:
                       cls = C_IMM;
      5'd15, 5'd16:    cls = C_MULDIV;
      5'd17, 5'd18:    cls = C_NEGNOT;
      5'd19:           cls = C_BR;
      5'd20:           cls = C_JR;
      5'd22:           cls = C_IN;
      5'd23:           cls = C_OUT;
      5'd24:           cls = C_MFHI;
      5'd25:           cls = C_MFLO;
      5'd26:           cls = C_NOP;
      5'd27:           cls = C_HALT;
      default:         cls = C_BAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= RESET;
      wait_cnt <= '0;
    end else begin
      case (state)
        RESET: state <= T0;
        T0: begin
          state    <= T1;
          wait_cnt <= WAIT_LOAD;
        end
        T1: begin
          if (wait_cnt != '0) wait_cnt <= wait_cnt - 3'd1;
          else                state    <= T2;
        end
        T2: state <= T3;
        T3: begin
          case (cls)
            C_HALT:                                         state <= HALT;
            C_BAD:                                          state <= FAULT;
            C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP:       state <= T0;
            default:                                        state <= T4;
          endcase
        end
        T4: state <= (cls == C_NEGNOT) ? T0 : T5;
        T5: begin
          if (cls == C_RRR || cls == C_IMM || cls == C_LDI) state <= T0;
          else                                               state <= T6;
          wait_cnt <= WAIT_LOAD;
        end
        T6: begin
          if (cls == C_LD) begin
            if (wait_cnt != '0) wait_cnt <= wait_cnt - 3'd1;
            else                state    <= T7;
          end else if (cls == C_ST) begin
            state <= T7;
          end else begin
            state <= T0;
          end
        end
        T7:      state <= T0;
        HALT:    state <= HALT;
        FAULT:   state <= FAULT;
        default: state <= RESET;
      endcase
    end
  end

  // Strobes decode state plus the live ir: the IR loads on the T2->T3 edge, so the
  // T3 decode cannot be precomputed into a register one cycle earlier.
  always_comb begin
    {PC_out, ZLow_out, ZHigh_out, HI_out, LO_out, C_out, In_port_out, MDR_out, BA_out} = '0;
    {PC_enable, IncPC, MAR_enable, MDR_enable, IR_enable, Y_enable, Z_enable, HI_enable,
     LO_enable} = '0;
    {Read, RAM_write_enable, out_port_enable, con_in, Gra, Grb, Grc, R_in, R_out} = '0;
    opcode     = '0;
    step       = state;
    run        = !(state == RESET || state == HALT || state == FAULT);
    illegal_op = (state == FAULT);
    case (state)
      T0: {PC_out, MAR_enable, IncPC, PC_enable} = '1;
      T1: {Read, MDR_enable} = '1;
      T2: {MDR_out, IR_enable} = '1;
      T3: begin
        case (cls)
          C_RRR, C_IMM:      {Grb, R_out, Y_enable} = '1;
          C_NEGNOT: begin
            {Grb, R_out, Z_enable} = '1;
            opcode = op;
          end
          C_MULDIV:          {Gra, R_out, Y_enable} = '1;
          C_LD, C_LDI, C_ST: {Grb, BA_out, Y_enable} = '1;
          C_BR:              {Gra, R_out, con_in} = '1;
          C_JR:              {Gra, R_out, PC_enable} = '1;
          C_IN:              {In_port_out, Gra, R_in} = '1;
          C_OUT:             {Gra, R_out, out_port_enable} = '1;
          C_MFHI:            {HI_out, Gra, R_in} = '1;
          C_MFLO:            {LO_out, Gra, R_in} = '1;
          default: ;
        endcase
      end
      T4: begin
        case (cls)
          C_RRR: begin
            {Grc, R_out, Z_enable} = '1;
            opcode = op;
          end
          C_IMM: begin
            {C_out, Z_enable} = '1;
            opcode = op;
          end
          C_NEGNOT:          {ZLow_out, Gra, R_in} = '1;
          C_MULDIV: begin
            {Grb, R_out, Z_enable} = '1;
            opcode = op;
          end
          C_LD, C_LDI, C_ST: begin
            {C_out, Z_enable} = '1;
            opcode = 5'b00011;
          end
          C_BR:              {PC_out, Y_enable} = '1;
          default: ;
        endcase
      end
      T5: begin
        case (cls)
          C_RRR, C_IMM, C_LDI: {ZLow_out, Gra, R_in} = '1;
          C_MULDIV:            {ZLow_out, LO_enable} = '1;
          C_LD, C_ST:          {ZLow_out, MAR_enable} = '1;
          C_BR: begin
            {C_out, Z_enable} = '1;
            opcode = 5'b00011;
          end
          default: ;
        endcase
      end
      T6: begin
        case (cls)
          C_MULDIV: {ZHigh_out, HI_enable} = '1;
          C_LD:     {Read, MDR_enable} = '1;
          C_ST:     {Gra, R_out, MDR_enable} = '1;
          C_BR: begin
            ZLow_out  = 1'b1;
            PC_enable = con_ff;
          end
          default: ;
        endcase
      end
      T7: begin
        case (cls)
          C_LD:    {MDR_out, Gra, R_in} = '1;
          C_ST:    RAM_write_enable = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule
